pong_match_controller: RTL

//  Match sequencer for the 2-player pong game. Sits beside the pixel/object generator and gates its motion:

---
 rtl/pong_match_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pong_match_controller.sv
// Match sequencer for two-player pong: idle -> serve countdown -> play -> point -> serve/over, with pause.
// Holds both scores, the winner and serve direction; motion is enabled only while in PLAY.
module pong_match_controller #(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               refr_tick,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               game_run,
    output logic               pos_reset,
    output logic               serve_right,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         DELAY_VAL = 8'(SERVE_DELAY);

    state_t             r_state;
    logic               r_start_q;
    logic               r_pause_q;
    logic [7:0]         r_serve_cnt;
    logic               r_point_right;
    logic               r_game_run;
    logic               r_pos_reset;
    logic               r_serve_right;
    logic [SCORE_W-1:0] r_score1;
    logic [SCORE_W-1:0] r_score2;
    logic [1:0]         r_winner;

    logic               w_start_press;
    logic               w_pause_press;
    logic [SCORE_W-1:0] w_score1_inc;
    logic [SCORE_W-1:0] w_score2_inc;

    assign w_start_press = start_btn & ~r_start_q;
    assign w_pause_press = pause_btn & ~r_pause_q;
    assign w_score1_inc  = r_score1 + SCORE_W'(1);
    assign w_score2_inc  = r_score2 + SCORE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b1;   // a button held through reset must not look like a press
            r_pause_q     <= 1'b1;
            r_serve_cnt   <= 8'd0;
            r_point_right <= 1'b0;
            r_game_run    <= 1'b0;
            r_pos_reset   <= 1'b0;
            r_serve_right <= 1'b1;
            r_score1      <= '0;
            r_score2      <= '0;
            r_winner      <= 2'b00;
        end else begin
            r_start_q   <= start_btn;
            r_pause_q   <= pause_btn;
            r_pos_reset <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (w_start_press) begin
                        r_state       <= S_SERVE;
                        r_pos_reset   <= 1'b1;
                        r_serve_cnt   <= DELAY_VAL;
                        r_score1      <= '0;
                        r_score2      <= '0;
                        r_winner      <= 2'b00;
                        r_serve_right <= 1'b1;
                    end
                end
                S_SERVE: begin
                    if (refr_tick) begin
                        if (r_serve_cnt == 8'd1) begin
                            r_state    <= S_PLAY;
                            r_game_run <= 1'b1;
                        end
                        if (r_serve_cnt != 8'd0)
                            r_serve_cnt <= r_serve_cnt - 8'd1;
                    end
                end
                S_PLAY: begin
                    // a simultaneous double miss is credited to player 2 only
                    if (miss_right || miss_left) begin
                        r_state       <= S_POINT;
                        r_game_run    <= 1'b0;
                        r_point_right <= miss_right;
                    end else if (w_pause_press) begin
                        r_state    <= S_PAUSE;
                        r_game_run <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (w_pause_press) begin
                        r_state    <= S_PLAY;
                        r_game_run <= 1'b1;
                    end
                end
                S_POINT: begin
                    r_serve_right <= r_point_right;
                    if (r_point_right) begin
                        r_score2 <= w_score2_inc;
                        if (w_score2_inc == WIN_VAL) begin
                            r_state  <= S_OVER;
                            r_winner <= 2'b10;
                        end else begin
                            r_state     <= S_SERVE;
                            r_pos_reset <= 1'b1;
                            r_serve_cnt <= DELAY_VAL;
                        end
                    end else begin
                        r_score1 <= w_score1_inc;
                        if (w_score1_inc == WIN_VAL) begin
                            r_state  <= S_OVER;
                            r_winner <= 2'b01;
                        end else begin
                            r_state     <= S_SERVE;
                            r_pos_reset <= 1'b1;
                            r_serve_cnt <= DELAY_VAL;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_game_run <= 1'b0;
                end
            endcase
        end
    end

    assign game_run    = r_game_run;
    assign pos_reset   = r_pos_reset;
    assign serve_right = r_serve_right;
    assign score1      = r_score1;
    assign score2      = r_score2;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule
